// File: rtl/clock_disp_pkg.sv
// Shared constants, digit-slot enum and BCD helper for the clock display scanner.
// Segment patterns are active-low, ordered {g,f,e,d,c,b,a}.
package clock_disp_pkg;

    localparam int NUM_DIGITS = 6;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;

    localparam logic [6:0] SEG_DIGIT [0:9] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
        7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
    };

    localparam logic [3:0] CODE_DASH  = 4'd10;
    localparam logic [3:0] CODE_BLANK = 4'd15;

    typedef enum logic [2:0] {
        DIG_SEC_ONES  = 3'd0,
        DIG_SEC_TENS  = 3'd1,
        DIG_MIN_ONES  = 3'd2,
        DIG_MIN_TENS  = 3'd3,
        DIG_HOUR_ONES = 3'd4,
        DIG_HOUR_TENS = 3'd5
    } digit_idx_e;

    // {tens, ones} of a 0..63 value; only meaningful for values up to 99
    function automatic logic [7:0] bcd_pair(input logic [5:0] v);
        return {4'(v / 6'd10), 4'(v % 6'd10)};
    endfunction

endpackage

// File: rtl/seg7_decode.sv
// 4-bit digit code to active-low seven-segment pattern.
// Codes 0-9 are digits, 10 is a dash, anything else is blank.
module seg7_decode
    import clock_disp_pkg::*;
(
    input  logic [3:0] code,
    output logic [6:0] pattern
);

    // code lookup
    always_comb begin
        pattern = SEG_BLANK;
        case (code)
            4'd0:      pattern = SEG_DIGIT[0];
            4'd1:      pattern = SEG_DIGIT[1];
            4'd2:      pattern = SEG_DIGIT[2];
            4'd3:      pattern = SEG_DIGIT[3];
            4'd4:      pattern = SEG_DIGIT[4];
            4'd5:      pattern = SEG_DIGIT[5];
            4'd6:      pattern = SEG_DIGIT[6];
            4'd7:      pattern = SEG_DIGIT[7];
            4'd8:      pattern = SEG_DIGIT[8];
            4'd9:      pattern = SEG_DIGIT[9];
            CODE_DASH: pattern = SEG_DASH;
            default:   pattern = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/clock_display_scan.sv
// Six-digit multiplexed HH.MM.SS display driver with per-frame input snapshot,
// anti-ghosting blank window and edit-mode blink of the hour/minute digits.
module clock_display_scan
    import clock_disp_pkg::*;
#(
    parameter int CLK_FRQ    = 100000000,
    parameter int REFRESH_HZ = 1000,
    parameter int BLANK_CYC  = 16,
    parameter int BLINK_HZ   = 2
)(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] second,
    input  logic [5:0] minute,
    input  logic [4:0] hour,
    input  logic       idle_mode,
    input  logic       run_mode,
    input  logic       edit_mode,
    output logic [5:0] an,
    output logic [6:0] seg,
    output logic       dp
);

    localparam int DIGIT_CYC = CLK_FRQ / (REFRESH_HZ * NUM_DIGITS);
    localparam int BLINK_CYC = CLK_FRQ / (2 * BLINK_HZ);
    localparam int DIV_W     = $clog2(DIGIT_CYC);
    localparam int BLK_W     = $clog2(BLINK_CYC);

    logic [DIV_W-1:0] div_r, div_next_s;
    digit_idx_e       idx_r, idx_next_s, idx_adv_s;
    logic             wrap_s, first_r, take_s;
    logic [5:0]       snap_sec_r, snap_min_r, snap_sec_next_s, snap_min_next_s;
    logic [4:0]       snap_hour_r, snap_hour_next_s;
    logic             snap_run_r, snap_edit_r, snap_run_next_s, snap_edit_next_s;
    logic [BLK_W-1:0] blink_cnt_r, blink_cnt_next_s;
    logic             blink_on_r, blink_on_next_s, edit_prev_r, edit_rise_s;
    logic [7:0]       sec_bcd_s, min_bcd_s, hour_bcd_s;
    logic             sec_ok_s, min_ok_s, hour_ok_s, hm_blank_s;
    logic [3:0]       code_s;
    logic [6:0]       pat_s, seg_next_s;
    logic [5:0]       an_next_s;
    logic             dp_next_s;
    logic [5:0]       an_r;
    logic [6:0]       seg_r;
    logic             dp_r;
    logic             unused_idle_s;

    assign unused_idle_s = idle_mode;
    assign an  = an_r;
    assign seg = seg_r;
    assign dp  = dp_r;

    // slot divider, digit index and frame snapshot selection
    always_comb begin
        wrap_s     = (div_r == DIV_W'(DIGIT_CYC - 1));
        div_next_s = div_r + DIV_W'(1);
        idx_next_s = idx_r;
        case (idx_r)
            DIG_SEC_ONES:  idx_adv_s = DIG_SEC_TENS;
            DIG_SEC_TENS:  idx_adv_s = DIG_MIN_ONES;
            DIG_MIN_ONES:  idx_adv_s = DIG_MIN_TENS;
            DIG_MIN_TENS:  idx_adv_s = DIG_HOUR_ONES;
            DIG_HOUR_ONES: idx_adv_s = DIG_HOUR_TENS;
            default:       idx_adv_s = DIG_SEC_ONES;
        endcase
        if (wrap_s) begin
            div_next_s = '0;
            idx_next_s = idx_adv_s;
        end else begin
            div_next_s = div_r + DIV_W'(1);
            idx_next_s = idx_r;
        end
        take_s           = first_r | (wrap_s & (idx_r == DIG_HOUR_TENS));
        snap_sec_next_s  = take_s ? second    : snap_sec_r;
        snap_min_next_s  = take_s ? minute    : snap_min_r;
        snap_hour_next_s = take_s ? hour      : snap_hour_r;
        snap_run_next_s  = take_s ? run_mode  : snap_run_r;
        snap_edit_next_s = take_s ? edit_mode : snap_edit_r;
    end

    // blink phase: a fresh edit entry restarts the phase ON, beating any pending toggle
    always_comb begin
        edit_rise_s      = edit_mode & ~edit_prev_r;
        blink_cnt_next_s = blink_cnt_r;
        blink_on_next_s  = blink_on_r;
        if (edit_rise_s) begin
            blink_cnt_next_s = '0;
            blink_on_next_s  = 1'b1;
        end else if (blink_cnt_r == BLK_W'(BLINK_CYC - 1)) begin
            blink_cnt_next_s = '0;
            blink_on_next_s  = ~blink_on_r;
        end else begin
            blink_cnt_next_s = blink_cnt_r + BLK_W'(1);
            blink_on_next_s  = blink_on_r;
        end
    end

    // digit code for the slot that will be shown after this edge
    always_comb begin
        sec_bcd_s  = bcd_pair(snap_sec_next_s);
        min_bcd_s  = bcd_pair(snap_min_next_s);
        hour_bcd_s = bcd_pair({1'b0, snap_hour_next_s});
        sec_ok_s   = (snap_sec_next_s <= 6'd59);
        min_ok_s   = (snap_min_next_s <= 6'd59);
        hour_ok_s  = (snap_hour_next_s <= 5'd12);
        hm_blank_s = snap_edit_next_s & ~blink_on_next_s;
        code_s     = CODE_BLANK;
        case (idx_next_s)
            DIG_SEC_ONES:  code_s = sec_ok_s ? sec_bcd_s[3:0] : CODE_DASH;
            DIG_SEC_TENS:  code_s = sec_ok_s ? sec_bcd_s[7:4] : CODE_DASH;
            DIG_MIN_ONES:  code_s = hm_blank_s ? CODE_BLANK :
                                    (min_ok_s ? min_bcd_s[3:0] : CODE_DASH);
            DIG_MIN_TENS:  code_s = hm_blank_s ? CODE_BLANK :
                                    (min_ok_s ? min_bcd_s[7:4] : CODE_DASH);
            DIG_HOUR_ONES: code_s = hm_blank_s ? CODE_BLANK :
                                    (hour_ok_s ? hour_bcd_s[3:0] : CODE_DASH);
            DIG_HOUR_TENS: code_s = hm_blank_s ? CODE_BLANK :
                                    (!hour_ok_s ? CODE_DASH :
                                    ((snap_hour_next_s < 5'd10) ? CODE_BLANK : hour_bcd_s[7:4]));
            default:       code_s = CODE_BLANK;
        endcase
    end

    seg7_decode u_decode (
        .code    (code_s),
        .pattern (pat_s)
    );

    // drive pattern, anode and point together so the active digit never glitches
    always_comb begin
        an_next_s  = 6'b111111;
        seg_next_s = SEG_BLANK;
        dp_next_s  = 1'b1;
        if (div_next_s < DIV_W'(BLANK_CYC)) begin
            an_next_s  = 6'b111111;
            seg_next_s = SEG_BLANK;
            dp_next_s  = 1'b1;
        end else begin
            an_next_s  = ~(6'b000001 << idx_next_s);
            seg_next_s = pat_s;
            dp_next_s  = ~(snap_run_next_s & ((idx_next_s == DIG_MIN_ONES) ||
                                              (idx_next_s == DIG_HOUR_ONES)));
        end
    end

    // state and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_r       <= '0;
            idx_r       <= DIG_SEC_ONES;
            first_r     <= 1'b1;
            snap_sec_r  <= 6'd0;
            snap_min_r  <= 6'd0;
            snap_hour_r <= 5'd0;
            snap_run_r  <= 1'b0;
            snap_edit_r <= 1'b0;
            blink_cnt_r <= '0;
            blink_on_r  <= 1'b1;
            edit_prev_r <= 1'b0;
            an_r        <= 6'b111111;
            seg_r       <= SEG_BLANK;
            dp_r        <= 1'b1;
        end else begin
            div_r       <= div_next_s;
            idx_r       <= idx_next_s;
            first_r     <= 1'b0;
            snap_sec_r  <= snap_sec_next_s;
            snap_min_r  <= snap_min_next_s;
            snap_hour_r <= snap_hour_next_s;
            snap_run_r  <= snap_run_next_s;
            snap_edit_r <= snap_edit_next_s;
            blink_cnt_r <= blink_cnt_next_s;
            blink_on_r  <= blink_on_next_s;
            edit_prev_r <= edit_mode;
            an_r        <= an_next_s;
            seg_r       <= seg_next_s;
            dp_r        <= dp_next_s;
        end
    end

endmodule

// File: tb/tb_clock_display_scan.sv
// Directed scoreboard bench for clock_display_scan: expected display states are
// queued with the cycle they are due and compared at the falling clock edge.
module tb_clock_display_scan;

    logic       clk;
    logic       rst_n;
    logic [5:0] second;
    logic [5:0] minute;
    logic [4:0] hour;
    logic       idle_mode;
    logic       run_mode;
    logic       edit_mode;
    logic [5:0] an;
    logic [6:0] seg;
    logic       dp;

    int checks = 0;
    int errors = 0;
    int cyc;

    localparam logic [13:0] MASK_AN  = 14'h3F80;
    localparam logic [13:0] MASK_ALL = 14'h3FFF;
    localparam logic [13:0] ALL_OFF  = {6'h3F, 7'h7F, 1'b1};

    typedef struct {
        string       tag;
        int          at;
        logic [13:0] exp;
        logic [13:0] mask;
    } exp_t;

    exp_t sb[$];

    clock_display_scan #(
        .CLK_FRQ    (1200),
        .REFRESH_HZ (20),
        .BLANK_CYC  (2),
        .BLINK_HZ   (10)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .second    (second),
        .minute    (minute),
        .hour      (hour),
        .idle_mode (idle_mode),
        .run_mode  (run_mode),
        .edit_mode (edit_mode),
        .an        (an),
        .seg       (seg),
        .dp        (dp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // cycles since reset release; equals the expected divider position
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    function automatic logic [6:0] dig(input int v);
        case (v)
            0: return 7'b1000000;
            1: return 7'b1111001;
            2: return 7'b0100100;
            3: return 7'b0110000;
            4: return 7'b0011001;
            5: return 7'b0010010;
            6: return 7'b0000010;
            7: return 7'b1111000;
            8: return 7'b0000000;
            9: return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    function automatic logic [6:0] exp_seg(input int d, input int h, input int m,
                                           input int s, input bit hm_off);
        if (d >= 2 && hm_off) return 7'b1111111;
        case (d)
            0: return (s > 59) ? 7'b0111111 : dig(s % 10);
            1: return (s > 59) ? 7'b0111111 : dig(s / 10);
            2: return (m > 59) ? 7'b0111111 : dig(m % 10);
            3: return (m > 59) ? 7'b0111111 : dig(m / 10);
            4: return (h > 12) ? 7'b0111111 : dig(h % 10);
            default: return (h > 12) ? 7'b0111111 : ((h < 10) ? 7'b1111111 : dig(h / 10));
        endcase
    endfunction

    task automatic chk(input string tag, input logic [13:0] exp, input logic [13:0] mask);
        logic [13:0] obs;
        obs = {an, seg, dp} & mask;
        checks++;
        assert (obs === (exp & mask)) else begin
            errors++;
            $error("FAIL %s: observed an=%b seg=%b dp=%b expected an=%b seg=%b dp=%b",
                   tag, obs[13:8], obs[7:1], obs[0],
                   exp[13:8] & mask[13:8], exp[7:1] & mask[7:1], exp[0] & mask[0]);
        end
    endtask

    task automatic wait_until(input int t);
        int guard;
        guard = 0;
        while (cyc != t && guard < 1000) begin
            @(negedge clk);
            guard++;
        end
        checks++;
        assert (cyc == t) else begin
            errors++;
            $error("FAIL wait_c%0d: observed cycle %0d expected %0d", t, cyc, t);
        end
    endtask

    task automatic push(input string tag, input int at, input logic [13:0] exp,
                        input logic [13:0] mask);
        exp_t e;
        e.tag  = tag;
        e.at   = at;
        e.exp  = exp;
        e.mask = mask;
        sb.push_back(e);
    endtask

    task automatic push_frame(input int f, input int h, input int m, input int s,
                              input bit run, input bit hm_off);
        int          base;
        logic [5:0]  an_on;
        logic [13:0] lit;
        for (int d = 0; d < 6; d++) begin
            base  = 60 * f + 10 * d;
            an_on = ~(6'b000001 << d);
            lit   = {an_on, exp_seg(d, h, m, s, hm_off), !(run && (d == 2 || d == 4))};
            push($sformatf("f%0d_d%0d_gap0", f, d), base,     ALL_OFF, MASK_AN);
            push($sformatf("f%0d_d%0d_gap1", f, d), base + 1, ALL_OFF, MASK_AN);
            push($sformatf("f%0d_d%0d_on",   f, d), base + 2, lit,     MASK_ALL);
            push($sformatf("f%0d_d%0d_end",  f, d), base + 9, lit,     MASK_ALL);
        end
    endtask

    task automatic drain_until(input int limit);
        exp_t e;
        while (sb.size() > 0 && sb[0].at <= limit) begin
            e = sb.pop_front();
            wait_until(e.at);
            chk(e.tag, e.exp, e.mask);
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        hour      = 5'd12;
        minute    = 6'd34;
        second    = 6'd56;
        idle_mode = 1'b0;
        run_mode  = 1'b1;
        edit_mode = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_hold", ALL_OFF, MASK_ALL);
        rst_n = 1'b1;

        // 12:34:56 running, first two frames
        push_frame(0, 12, 34, 56, 1'b1, 1'b0);
        push_frame(1, 12, 34, 56, 1'b1, 1'b0);
        drain_until(119);

        // leading-zero hour blanking
        hour = 5'd7; minute = 6'd5; second = 6'd0;
        push_frame(2, 7, 5, 0, 1'b1, 1'b0);
        drain_until(179);

        // mid-frame changes stay hidden until the next snapshot
        minute = 6'd10;
        push_frame(3, 7, 10, 0, 1'b1, 1'b0);
        drain_until(212);
        minute = 6'd11;
        hour   = 5'd8;
        drain_until(239);
        push_frame(4, 8, 11, 0, 1'b1, 1'b0);
        drain_until(299);

        // out-of-range minute and hour
        minute = 6'd60; hour = 5'd13; second = 6'd42;
        push_frame(5, 13, 60, 42, 1'b1, 1'b0);
        drain_until(359);

        // edit entered at frame start: lit, blanked, lit
        hour = 5'd12; minute = 6'd34; second = 6'd56;
        run_mode = 1'b0; edit_mode = 1'b1;
        push_frame(6, 12, 34, 56, 1'b0, 1'b0);
        push_frame(7, 12, 34, 56, 1'b0, 1'b1);
        push_frame(8, 12, 34, 56, 1'b0, 1'b0);
        drain_until(539);

        // asynchronous reset while minute tens is lit
        edit_mode = 1'b0; run_mode = 1'b1;
        wait_until(572);
        chk("pre_reset_d3", {6'b110111, dig(3), 1'b1}, MASK_ALL);
        rst_n = 1'b0;
        #1;
        chk("async_reset", ALL_OFF, MASK_ALL);
        repeat (3) @(negedge clk);
        run_mode = 1'b0;
        rst_n    = 1'b1;
        push("rel_c0", 0, ALL_OFF, MASK_AN);
        push("rel_c1", 1, ALL_OFF, MASK_AN);
        push("rel_c2", 2, {6'b111110, dig(6), 1'b1}, MASK_ALL);
        drain_until(2);

        // edit raised mid-frame: blink phase is measured from the edge, not the frame
        wait_until(25);
        edit_mode = 1'b1;
        push("blk_d0_lit",   62,  {6'b111110, dig(6), 1'b1},      MASK_ALL);
        push("blk_d2_on",    82,  {6'b111011, dig(4), 1'b1},      MASK_ALL);
        push("blk_d2_off",   89,  {6'b111011, 7'b1111111, 1'b1},  MASK_ALL);
        push("blk_d3_off",   92,  {6'b110111, 7'b1111111, 1'b1},  MASK_ALL);
        push("blk_d0_keep",  122, {6'b111110, dig(6), 1'b1},      MASK_ALL);
        push("blk_f2d2_off", 142, {6'b111011, 7'b1111111, 1'b1},  MASK_ALL);
        push("blk_f2d2_on",  149, {6'b111011, dig(4), 1'b1},      MASK_ALL);
        drain_until(149);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/clock_display_scan.md
# clock_display_scan

Downstream display stage for the digital clock: consumes the clock's hour/minute/second values and mode flags and drives a 6-digit, time-multiplexed, active-low seven-segment display in the form HH.MM.SS. Inputs are snapshotted once per refresh frame so the display never tears, and the hour and minute digits blink while the clock is in edit mode. All outputs are registered.

## Interface
- CLK_FRQ, 100000000: system clock frequency in Hz.
- REFRESH_HZ, 1000: full 6-digit frame rate. Per-digit period DIGIT_CYC = CLK_FRQ/(REFRESH_HZ*6), using integer division; must be > BLANK_CYC + 1.
- BLANK_CYC, 16: anti-ghosting cycles with all anodes off after each digit switch.
- BLINK_HZ, 2: edit-mode blink rate. Half-period BLINK_CYC = CLK_FRQ/(2*BLINK_HZ).

Ports:
- clk  in  1: system clock. One clock domain; all logic on posedge.
- rst_n  in  1: reset, asynchronous, active-low.
- second  in  6: seconds, binary.
- minute  in  6: minutes, binary.
- hour  in  5: hours, binary (12-hour range, 0 after clock reset).
- idle_mode, run_mode, edit_mode  in  1 each: clock state flags.
- an  out  6: digit anodes, active-low. an[0] = seconds ones … an[5] = hour tens.
- seg  out  7: segments {g,f,e,d,c,b,a}, active-low.
- dp  out  1: decimal point, active-low.

## Operation
- Reset values: an=6'b111111, seg=7'b1111111, dp=1, digit index 0, divider 0, blink phase ON, snapshot regs 0.
- Digit divider counts 0..DIGIT_CYC-1. At wrap, the digit index advances 0→1→…→5→0.
- Snapshot: when the index advances to 0 (and on the first tick after reset), latch second, minute, hour, run_mode and edit_mode. All decoding for the frame uses the snapshot.
- Pair validity: second or minute > 59 → that pair shows dash/dash (7'b0111111). Hour > 12 → hour pair shows dash/dash.
- BCD: tens = v/10, ones = v%10 for each 6-bit pair. Hour tens digit is blanked (7'b1111111) when hour < 10.
- Digit map: 0 sec ones, 1 sec tens, 2 min ones, 3 min tens, 4 hour ones, 5 hour tens.
- dp: low on digits 2 and 4 when snapshot run_mode=1; otherwise high.
- Blink: a free-running counter toggles the phase every BLINK_CYC cycles. On an edit_mode rising edge (live input), the counter is cleared and the phase forced ON. When snapshot edit_mode=1 and phase=OFF, digits 2–5 are blanked; the seconds digits are always shown.
- idle_mode has no effect other than through run_mode/edit_mode being low.

## Timing
- The divider counts cycles 0..BLANK_CYC-1 of each digit slot as anti-ghosting: an = all ones.
- From cycle BLANK_CYC to the end of the slot, exactly one an bit is low, and seg/dp hold that digit's pattern.
- seg/dp update in the same cycle the anode re-enables, so there is no glitch on the active digit.
- Input-to-display latency is at most one frame + BLANK_CYC + 1 cycles.
- Input changes mid-frame are invisible until the next snapshot.
- rst_n low forces reset values immediately, asynchronously, at any point of a frame. After rst_n rises, the first active anode is an[0], at cycle BLANK_CYC.
- Divider wrap coinciding with blink toggle: both take effect in the same cycle, with no priority between them.
- Edit_mode rising coinciding with a blink toggle: the clear/force-ON wins.

## Structure
- Package clock_disp_pkg holds:
  - NUM_DIGITS=6
  - SEG_BLANK, SEG_DASH
  - the SEG_DIGIT[0:9] pattern constants (0=7'b1000000, 1=7'b1111001, …, 9=7'b0010000)
  - the digit-index enum.
- Sub-module seg7_decode: 4-bit code → 7-bit pattern. Codes 10 = dash, 15 = blank, others = blank. Purely combinational, instantiated once on the muxed digit.
- Expected size: ~200 RTL lines.

## Test plan
Bench parameters: CLK_FRQ=1200, REFRESH_HZ=20 (DIGIT_CYC=10), BLANK_CYC=2, BLINK_HZ=10 (BLINK_CYC=60).
- Reset, then hold hour=12, minute=34, second=56, run_mode=1 for 2 frames → second frame shows:
  - an[0] with seg for 6, an[1] for 5, an[2] for 4 with dp=0, an[3] for 3, an[4] for 2 with dp=0, an[5] for 1.
  - an is all-ones for 2 cycles at each slot start.
- hour=7, minute=5, second=0 → digit 5 shows blank, digit 4 shows 7, digit 3 shows 0, digit 2 shows 5.
- Change minute from 10 to 11 while digit 3 is active → the current frame still shows 10; the next frame shows 11.
- minute=60, hour=13 → digits 2–5 show dash; seconds remain correct.
- Raise edit_mode at frame start → the next frame shows digits 2–5 lit. Within the following frames, once 60 cycles have elapsed from the edge, digits 2–5 show blank while digits 0–1 stay lit. The pattern alternates every 60 cycles.
- Pull rst_n low mid-slot while an[3] is active → in the same cycle an=6'b111111, seg=7'b1111111, dp=1. After release, an[0] is the first digit enabled, at cycle 2.
